// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID boot checker.
package sysid_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIdReq,
    StIdWait,
    StTsReq,
    StTsWait,
    StDone
  } sysid_state_e;

  localparam logic [1:0] FAIL_NONE    = 2'd0;
  localparam logic [1:0] FAIL_ID      = 2'd1;
  localparam logic [1:0] FAIL_TS      = 2'd2;
  localparam logic [1:0] FAIL_TIMEOUT = 2'd3;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_timeout_ctr.sv
// Per-read cycle counter; expired flags the last cycle a read may still complete in.
module sysid_timeout_ctr #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= 16'd0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  assign expired = (count == 16'(LIMIT - 1));

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches the system-ID and timestamp words and checks them
// against the build-time expected values.
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd28,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1718117590,
  parameter int unsigned TIMEOUT_CYCLES     = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  fail_code,
  output logic [31:0] id_word,
  output logic [31:0] ts_word
);

  sysid_state_e state;
  logic id_bad;
  logic in_req, in_wait, accepted, responded, expired, timed_out, ctr_clear, ts_mismatch;

  assign in_req      = (state == StIdReq) || (state == StTsReq);
  assign in_wait     = (state == StIdWait) || (state == StTsWait);
  assign accepted    = in_req && !avm_waitrequest;
  assign responded   = in_wait && avm_readdatavalid;
  // A completing event in the final counted cycle beats the timeout.
  assign timed_out   = (in_req || in_wait) && expired && !accepted && !responded;
  assign ctr_clear   = (((state == StIdle) || (state == StDone)) && start) ||
                       ((state == StIdWait) && avm_readdatavalid);
  assign ts_mismatch = (avm_readdata != EXPECTED_TIMESTAMP);

  sysid_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clock   (clock),
    .reset   (reset),
    .clear   (ctr_clear),
    .enable  (in_req || in_wait),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= StIdle;
      avm_read    <= 1'b0;
      avm_address <= SYSID_ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_code   <= FAIL_NONE;
      id_word     <= 32'd0;
      ts_word     <= 32'd0;
      id_bad      <= 1'b0;
    end else if (timed_out) begin
      // Read is withdrawn even under waitrequest; diagnostic path only.
      state     <= StDone;
      avm_read  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b1;
      pass      <= 1'b0;
      fail_code <= FAIL_TIMEOUT;
    end else begin
      unique case (state)
        StIdle, StDone: begin
          if (start) begin
            state       <= StIdReq;
            avm_read    <= 1'b1;
            avm_address <= SYSID_ADDR_ID;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_code   <= FAIL_NONE;
            id_word     <= 32'd0;
            ts_word     <= 32'd0;
            id_bad      <= 1'b0;
          end
        end
        StIdReq: begin
          if (!avm_waitrequest) begin
            state    <= StIdWait;
            avm_read <= 1'b0;
          end
        end
        StIdWait: begin
          if (avm_readdatavalid) begin
            state       <= StTsReq;
            id_word     <= avm_readdata;
            id_bad      <= (avm_readdata != EXPECTED_ID);
            avm_read    <= 1'b1;
            avm_address <= SYSID_ADDR_TS;
          end
        end
        StTsReq: begin
          if (!avm_waitrequest) begin
            state    <= StTsWait;
            avm_read <= 1'b0;
          end
        end
        StTsWait: begin
          if (avm_readdatavalid) begin
            state     <= StDone;
            ts_word   <= avm_readdata;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= !id_bad && !ts_mismatch;
            fail_code <= id_bad ? FAIL_ID : (ts_mismatch ? FAIL_TS : FAIL_NONE);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
